// File: rtl/xif_offload_issuer.sv
// Offload issuer: forwards one instruction at a time to an X-interface coprocessor,
// commits it, and optionally waits (bounded) for its result to write back.
module xif_offload_issuer #(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  off_valid_i,
    output logic                  off_ready_o,
    input  logic [31:0]           off_instr_i,
    input  logic [31:0]           off_rs1_i,
    input  logic [31:0]           off_rs2_i,
    input  logic [X_ID_WIDTH-1:0] off_id_i,
    input  logic                  off_kill_i,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    input  logic                  issue_accept_i,
    input  logic                  issue_writeback_i,
    output logic [31:0]           issue_instr_o,
    output logic [63:0]           issue_rs_o,
    output logic [X_ID_WIDTH-1:0] issue_id_o,
    output logic                  commit_valid_o,
    output logic                  commit_kill_o,
    output logic [X_ID_WIDTH-1:0] commit_id_o,
    input  logic                  result_valid_i,
    output logic                  result_ready_o,
    input  logic [X_ID_WIDTH-1:0] result_id_i,
    input  logic [31:0]           result_data_i,
    input  logic [4:0]            result_rd_i,
    input  logic                  result_we_i,
    output logic                  wb_valid_o,
    output logic [4:0]            wb_rd_o,
    output logic [31:0]           wb_data_o,
    output logic                  illegal_o,
    output logic                  timeout_o,
    output logic                  busy_o
);

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StCommit, StWaitRes} state_e;

    state_e                state_q, state_d;
    logic [31:0]           instr_q, instr_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [X_ID_WIDTH-1:0] id_q, id_d;
    logic                  kill_pending_q, kill_pending_d;
    logic                  expect_res_q, expect_res_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [31:0]           wb_data_q, wb_data_d;
    logic                  kill_now;
    logic                  res_match;

    assign kill_now  = kill_pending_q | off_kill_i;
    assign res_match = result_valid_i && (result_id_i == id_q);

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        id_d           = id_q;
        kill_pending_d = kill_pending_q;
        expect_res_d   = expect_res_q;
        cnt_d          = cnt_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        off_ready_o    = 1'b0;
        issue_valid_o  = 1'b0;
        commit_valid_o = 1'b0;
        commit_kill_o  = 1'b0;
        result_ready_o = 1'b0;
        illegal_o      = 1'b0;
        timeout_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                off_ready_o = 1'b1;
                if (off_valid_i) begin
                    instr_d        = off_instr_i;
                    rs1_d          = off_rs1_i;
                    rs2_d          = off_rs2_i;
                    id_d           = off_id_i;
                    kill_pending_d = 1'b0;
                    expect_res_d   = 1'b0;
                    state_d        = StIssue;
                end
            end
            StIssue: begin
                issue_valid_o = 1'b1;
                if (off_kill_i) kill_pending_d = 1'b1;
                if (issue_ready_i) begin
                    if (issue_accept_i) begin
                        expect_res_d = issue_writeback_i;
                        state_d      = StCommit;
                    end else begin
                        // A flushed instruction being rejected is not an error.
                        illegal_o = ~kill_now;
                        state_d   = StIdle;
                    end
                end
            end
            StCommit: begin
                commit_valid_o = 1'b1;
                commit_kill_o  = kill_now;
                if (kill_now || !expect_res_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = '0;
                    state_d = StWaitRes;
                end
            end
            StWaitRes: begin
                result_ready_o = 1'b1;
                // A match beats a timeout landing in the same cycle.
                if (res_match) begin
                    state_d    = StIdle;
                    wb_valid_d = result_we_i;
                    if (result_we_i) begin
                        wb_rd_d   = result_rd_i;
                        wb_data_d = result_data_i;
                    end
                end else if (cnt_q == CntLast) begin
                    timeout_o = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            instr_q        <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            id_q           <= '0;
            kill_pending_q <= 1'b0;
            expect_res_q   <= 1'b0;
            cnt_q          <= '0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            id_q           <= id_d;
            kill_pending_q <= kill_pending_d;
            expect_res_q   <= expect_res_d;
            cnt_q          <= cnt_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
        end
    end

    assign issue_instr_o = instr_q;
    assign issue_rs_o    = {rs2_q, rs1_q};
    assign issue_id_o    = id_q;
    assign commit_id_o   = id_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_data_o     = wb_data_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_xif_offload_issuer.sv
// Scoreboard bench for xif_offload_issuer: stimulus queues expected events, a negedge
// monitor pops and compares every commit / illegal / timeout / writeback the DUT emits.
module tb_xif_offload_issuer;

    localparam int KCommit  = 0;
    localparam int KIllegal = 1;
    localparam int KTimeout = 2;
    localparam int KWb      = 3;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        off_valid = 1'b0, off_ready, off_kill = 1'b0;
    logic [31:0] off_instr = '0, off_rs1 = '0, off_rs2 = '0;
    logic [3:0]  off_id = '0;
    logic        issue_valid, issue_ready = 1'b0, issue_accept = 1'b0, issue_wb = 1'b0;
    logic [31:0] issue_instr;
    logic [63:0] issue_rs;
    logic [3:0]  issue_id, commit_id, result_id = '0;
    logic        commit_valid, commit_kill;
    logic        result_valid = 1'b0, result_ready, result_we = 1'b0;
    logic [31:0] result_data = '0, wb_data;
    logic [4:0]  result_rd = '0, wb_rd;
    logic        wb_valid, illegal, timeout, busy;

    int  checks = 0;
    int  passes = 0;
    ev_t sb[$];

    always #5 clk = ~clk;

    xif_offload_issuer #(.X_ID_WIDTH(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .off_valid_i(off_valid), .off_ready_o(off_ready),
        .off_instr_i(off_instr), .off_rs1_i(off_rs1), .off_rs2_i(off_rs2),
        .off_id_i(off_id), .off_kill_i(off_kill),
        .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
        .issue_accept_i(issue_accept), .issue_writeback_i(issue_wb),
        .issue_instr_o(issue_instr), .issue_rs_o(issue_rs), .issue_id_o(issue_id),
        .commit_valid_o(commit_valid), .commit_kill_o(commit_kill), .commit_id_o(commit_id),
        .result_valid_i(result_valid), .result_ready_o(result_ready),
        .result_id_i(result_id), .result_data_i(result_data),
        .result_rd_i(result_rd), .result_we_i(result_we),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .illegal_o(illegal), .timeout_o(timeout), .busy_o(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got kind %0d a=0x%0h b=0x%0h, expected none",
                     kind, a, b);
        end else begin
            e = sb.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            check("event_a", {32'd0, a}, {32'd0, e.a});
            check("event_b", {32'd0, b}, {32'd0, e.b});
        end
    endtask

    always @(negedge clk) begin
        if (commit_valid) observe(KCommit, 32'(commit_id), 32'(commit_kill));
        if (illegal)      observe(KIllegal, 32'd0, 32'd0);
        if (timeout)      observe(KTimeout, 32'd0, 32'd0);
        if (wb_valid)     observe(KWb, 32'(wb_rd), wb_data);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in ISSUE.
    task automatic offload(input logic [3:0] id, input logic [31:0] instr,
                           input logic [31:0] rs1, input logic [31:0] rs2);
        off_valid = 1'b1; off_id = id; off_instr = instr; off_rs1 = rs1; off_rs2 = rs2;
        step();
        off_valid = 1'b0;
    endtask

    // Handshake in ISSUE; leaves the DUT in COMMIT (accepted) or IDLE (rejected).
    task automatic handshake(input logic acc, input logic wbk);
        issue_ready = 1'b1; issue_accept = acc; issue_wb = wbk;
        step();
        issue_ready = 1'b0; issue_accept = 1'b0; issue_wb = 1'b0;
    endtask

    task automatic result(input logic [3:0] id, input logic [4:0] rd,
                          input logic [31:0] data, input logic we);
        result_valid = 1'b1; result_id = id; result_rd = rd; result_data = data;
        result_we = we;
        step();
        result_valid = 1'b0; result_we = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_off_ready", 64'(off_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outs", 64'({issue_valid, commit_valid, result_ready, wb_valid, illegal,
                                timeout}), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Basic accepted offload with writeback; coprocessor stalls issue for 2 cycles.
        offload(4'd3, 32'h0000_003B, 32'd5, 32'd7);
        check("iss_valid", 64'(issue_valid), 64'd1);
        check("iss_off_ready", 64'(off_ready), 64'd0);
        check("iss_busy", 64'(busy), 64'd1);
        step();
        step();
        check("iss_hold_valid", 64'(issue_valid), 64'd1);
        check("iss_instr", 64'(issue_instr), 64'h3B);
        check("iss_rs", issue_rs, {32'd7, 32'd5});
        check("iss_id", 64'(issue_id), 64'd3);
        expect_ev(KCommit, 32'd3, 32'd0);
        handshake(1'b1, 1'b1);
        step();
        check("wait_res_ready", 64'(result_ready), 64'd1);
        expect_ev(KWb, 32'd10, 32'h0C);
        result(4'd3, 5'd10, 32'h0C, 1'b1);
        step();
        check("t1_idle", 64'(off_ready), 64'd1);

        // Rejected offload raises illegal and returns to IDLE.
        offload(4'd1, 32'h0000_0033, 32'd0, 32'd0);
        expect_ev(KIllegal, 32'd0, 32'd0);
        handshake(1'b0, 1'b0);
        check("t2_off_ready", 64'(off_ready), 64'd1);
        check("t2_busy", 64'(busy), 64'd0);

        // Kill during ISSUE: killed commit, no WAIT_RES.
        offload(4'd2, 32'h0000_1033, 32'd1, 32'd2);
        off_kill = 1'b1;
        step();
        off_kill = 1'b0;
        check("t3_hold_valid", 64'(issue_valid), 64'd1);
        expect_ev(KCommit, 32'd2, 32'd1);
        handshake(1'b1, 1'b1);
        step();
        check("t3_no_wait", 64'(busy), 64'd0);

        // Killed and rejected in the same cycle: no illegal.
        offload(4'd6, 32'h0000_2033, 32'd0, 32'd0);
        off_kill = 1'b1;
        handshake(1'b0, 1'b0);
        off_kill = 1'b0;
        check("t3b_idle", 64'(busy), 64'd0);

        // Timeout on the 8th WAIT_RES cycle.
        offload(4'd4, 32'h0000_003B, 32'd0, 32'd0);
        expect_ev(KCommit, 32'd4, 32'd0);
        handshake(1'b1, 1'b1);
        step();
        for (int c = 1; c < 8; c++) begin
            check("t4_no_early_timeout", 64'(timeout), 64'd0);
            step();
        end
        expect_ev(KTimeout, 32'd0, 32'd0);
        step();
        check("t4_idle_after_timeout", 64'(busy), 64'd0);

        // Mismatched result dropped, matching one written back.
        offload(4'd4, 32'h0000_003B, 32'd0, 32'd0);
        expect_ev(KCommit, 32'd4, 32'd0);
        handshake(1'b1, 1'b1);
        step();
        result(4'd5, 5'd9, 32'h1111_1111, 1'b1);
        check("t5_still_waiting", 64'(result_ready), 64'd1);
        expect_ev(KWb, 32'd3, 32'hDEAD_BEEF);
        result(4'd4, 5'd3, 32'hDEAD_BEEF, 1'b1);
        step();
        check("t5_idle", 64'(busy), 64'd0);

        // Match in the same cycle the counter expires: writeback wins.
        offload(4'd9, 32'h0000_003B, 32'd0, 32'd0);
        expect_ev(KCommit, 32'd9, 32'd0);
        handshake(1'b1, 1'b1);
        step();
        for (int c = 1; c < 8; c++) step();
        expect_ev(KWb, 32'd31, 32'hA5A5_0001);
        result(4'd9, 5'd31, 32'hA5A5_0001, 1'b1);
        step();
        check("t6_idle", 64'(busy), 64'd0);

        // Reset during WAIT_RES abandons the offload.
        offload(4'd1, 32'h0000_003B, 32'd0, 32'd0);
        expect_ev(KCommit, 32'd1, 32'd0);
        handshake(1'b1, 1'b1);
        step();
        check("t7_waiting", 64'(result_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_busy", 64'(busy), 64'd0);
        check("t7_rst_outs", 64'({issue_valid, commit_valid, result_ready, wb_valid}), 64'd0);
        check("t7_rst_off_ready", 64'(off_ready), 64'd1);
        step();
        rst_n = 1'b1;
        result(4'd1, 5'd7, 32'h5555_AAAA, 1'b1);
        step();
        step();
        check("t7_still_idle", 64'(busy), 64'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/xif_offload_issuer.md
XIF_OFFLOAD_ISSUER -- requirements
Module: xif_offload_issuer

Interface
REQ-001 Parameter X_ID_WIDTH, default 4, width of the offload instruction ID.
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles allowed in WAIT_RES; legal range 1..65535.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 off_valid_i  input  1  pipeline offers an instruction for offload.
REQ-006 off_ready_o  output  1  block can take a new offload.
REQ-007 off_instr_i / off_rs1_i / off_rs2_i  input  32 each  instruction word and source operands.
REQ-008 off_id_i  input  X_ID_WIDTH  instruction ID.
REQ-009 off_kill_i  input  1  pipeline flush request for the in-flight offload.
REQ-010 issue_valid_o  output  1  issue request valid.
REQ-011 issue_ready_i / issue_accept_i / issue_writeback_i  input  1 each  coprocessor issue response.
REQ-012 issue_instr_o  output  32  instruction word; issue_rs_o  output  64  {rs2,rs1}; issue_id_o  output  X_ID_WIDTH.
REQ-013 commit_valid_o / commit_kill_o  output  1 each; commit_id_o  output  X_ID_WIDTH.
REQ-014 result_valid_i  input  1; result_ready_o  output  1; result_id_i  input  X_ID_WIDTH; result_data_i  input  32; result_rd_i  input  5; result_we_i  input  1.
REQ-015 wb_valid_o  output  1; wb_rd_o  output  5; wb_data_o  output  32  register-file writeback.
REQ-016 illegal_o / timeout_o / busy_o  output  1 each  rejected offload, result timeout, FSM not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, COMMIT, WAIT_RES; busy_o = (state != IDLE).
REQ-018 IDLE: off_ready_o=1; on off_valid_i, latch instr, rs1, rs2, id, clear kill_pending, go to ISSUE next cycle.
REQ-019 ISSUE: issue_valid_o=1; issue_instr_o, issue_rs_o, issue_id_o SHALL hold latched values and remain stable until issue_ready_i=1 (no retraction).
REQ-020 ISSUE handshake (issue_valid_o & issue_ready_i): accept=0 -> pulse illegal_o for 1 cycle, go to IDLE; accept=1 -> store expect_res=issue_writeback_i, go to COMMIT.
REQ-021 COMMIT: commit_valid_o=1 for exactly 1 cycle, commit_id_o=latched id, commit_kill_o=kill_pending|off_kill_i.
REQ-022 After COMMIT: killed or expect_res=0 -> IDLE; otherwise -> WAIT_RES.
REQ-023 off_kill_i asserted in ISSUE SHALL set kill_pending; issue_valid_o stays high until handshake; a rejected killed offload SHALL NOT pulse illegal_o.
REQ-024 WAIT_RES: result_ready_o=1; result with result_id_i == latched id -> go to IDLE; if result_we_i=1, wb_valid_o=1 next cycle for 1 cycle with wb_rd_o=result_rd_i, wb_data_o=result_data_i.
REQ-025 WAIT_RES: result with mismatching ID SHALL be consumed and dropped, no writeback, state unchanged.
REQ-026 16-bit wait counter SHALL clear on entry to WAIT_RES, increment each WAIT_RES cycle without matching result; at count == TIMEOUT-1 without match, pulse timeout_o 1 cycle and go to IDLE.
REQ-027 Matching result in the same cycle as timeout SHALL win: writeback performed, timeout_o stays 0.
REQ-028 result_ready_o, issue_valid_o, commit_valid_o SHALL be 0 in all other states; off_ready_o=0 outside IDLE.
REQ-029 Each accepted offload produces at most one wb_valid_o pulse and at most one of illegal_o/timeout_o.

Reset
REQ-030 On rst_ni=0, FSM SHALL enter IDLE immediately, mid-operation included; all outputs 0 except off_ready_o, which SHALL be 1 once in IDLE; latches, kill_pending, expect_res, counter cleared.
REQ-031 An offload in flight at reset SHALL be abandoned with no commit, writeback or flag pulse after reset release.

Verification
REQ-032 Offload instr=0x0000003B, id=3, rs1=5, rs2=7; ready+accept+writeback after 2 cycles; result id=3, rd=10, data=0x0C, we=1 -> one commit (kill=0), wb_valid_o pulse rd=10 data=0x0C, back to IDLE.
REQ-033 Offload instr=0x00000033; ready=1, accept=0 -> illegal_o 1-cycle pulse, no commit_valid_o, off_ready_o=1 next cycle.
REQ-034 Accepted offload id=2, off_kill_i=1 during ISSUE -> commit_valid_o with commit_kill_o=1, commit_id_o=2, no WAIT_RES, no writeback.
REQ-035 TIMEOUT=8, accepted writeback offload, no result -> timeout_o pulse on 8th WAIT_RES cycle; result id=5 then id=4 (latched 4) -> first dropped, second written back.
REQ-036 rst_ni=0 during WAIT_RES -> busy_o=0, all handshake outputs 0 immediately; later stale result produces no wb_valid_o.
